// File: rtl/mul4_seq.sv
// -----------------------------------------------------------------------------
// mul4_seq -- sequential 4x4 unsigned shift-and-add multiplier
//
// Multiplies two 4-bit unsigned operands into an exact 8-bit product. It takes
// four iterations and uses one sum4_fa ripple adder as its only adder. Each
// iteration adds the multiplicand to the running partial product when the
// current multiplier LSB is set. It then shifts the 9-bit {carry, sum, mq}
// result right by one place.
//
// Ports:
//   clk      in   1  rising-edge clock
//   reset_n  in   1  asynchronous active-low reset
//   start    in   1  operation request, only looked at while idle
//   A        in   4  multiplicand, captured when start is accepted
//   B        in   4  multiplier, captured when start is accepted
//   P        out  8  product register, holds the most recent result
//   busy     out  1  high while iterating
//   done     out  1  single-cycle pulse marking a fresh product on P
//
// Timing: the edge that accepts start is edge 1. Edges 2-5 iterate, and edge 5
// also loads P. done is high for the cycle after edge 5, and edge 6 returns to
// idle. A new operation can start every 6 cycles.
// -----------------------------------------------------------------------------
module mul4_seq (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] P,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [3:0] r_acc;      // upper half of the running product
  logic [3:0] r_mq;       // multiplier bits still to consume / low product bits
  logic [3:0] r_mcand;    // captured multiplicand
  logic [1:0] r_cnt;      // iteration index 0..3
  logic [7:0] r_p;        // result register

  logic [3:0] w_addend;
  logic [3:0] w_sum;
  logic       w_carry;
  logic [3:0] w_acc_next;
  logic [3:0] w_mq_next;
  logic       w_last_iter;
  logic       w_accept;

  // ---------------------------------------------------------------------------
  // Adder: the partial product plus a multiplicand gated by the current LSB.
  // ---------------------------------------------------------------------------
  assign w_addend = r_mq[0] ? r_mcand : 4'h0;

  sum4_fa u_add (
    .A         (r_acc),
    .B         (w_addend),
    .carry_in  (1'b0),
    .S         (w_sum),
    .carry_out (w_carry)
  );

  // The 9-bit {carry, sum, mq} result is shifted right by one place. The adder
  // carry becomes the new acc MSB, so it is never lost. The sum LSB moves into
  // the top of mq and becomes a finished low product bit.
  assign w_acc_next  = {w_carry, w_sum[3:1]};
  assign w_mq_next   = {w_sum[0], r_mq[3:1]};
  assign w_last_iter = (r_cnt == 2'd3);
  assign w_accept    = (r_state == S_IDLE) && start;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_CALC;
      S_CALC:  if (w_last_iter) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. These are decoded from the state register only, so there is
  // no path from any input to an output.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_CALC:  busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers. Operands are captured only when start is accepted.
  // start during CALC or DONE is neither queued nor re-captured.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc   <= 4'h0;
      r_mq    <= 4'h0;
      r_mcand <= 4'h0;
      r_cnt   <= 2'd0;
    end else if (w_accept) begin
      r_acc   <= 4'h0;
      r_mq    <= B;
      r_mcand <= A;
      r_cnt   <= 2'd0;
    end else if (r_state == S_CALC) begin
      r_acc   <= w_acc_next;
      r_mq    <= w_mq_next;
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  // P is loaded straight from the final shift, not from r_acc/r_mq one cycle
  // later. This means it is already valid in the DONE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p <= 8'h00;
    end else if ((r_state == S_CALC) && w_last_iter) begin
      r_p <= {w_acc_next, w_mq_next};
    end
  end

  assign P = r_p;

endmodule

// -----------------------------------------------------------------------------
// sum4_fa -- 4-bit ripple-carry adder built from full-adder cells
//
// Ports:
//   A, B       in   4  addends
//   carry_in   in   1  carry into bit 0
//   S          out  4  sum
//   carry_out  out  1  carry out of bit 3
// -----------------------------------------------------------------------------
module sum4_fa (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       carry_in,
  output logic [3:0] S,
  output logic       carry_out
);

  logic [4:0] w_c;

  assign w_c[0] = carry_in;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fa
    assign S[gi]     = A[gi] ^ B[gi] ^ w_c[gi];
    assign w_c[gi+1] = (A[gi] & B[gi]) | (w_c[gi] & (A[gi] ^ B[gi]));
  end

  assign carry_out = w_c[4];

endmodule

// File: tb/tb_mul4_seq.sv
module tb_mul4_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] A = 4'h0;
  logic [3:0] B = 4'h0;
  wire  [7:0] P;
  wire        busy;
  wire        done;

  mul4_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .A       (A),
    .B       (B),
    .P       (P),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model. It only tracks how many edges have passed since start
  // was accepted, plus the arithmetic product.
  int m_age  = -1;
  int m_pend = 0;
  int m_p    = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_age  = -1;
      m_pend = 0;
      m_p    = 0;
    end else if (m_age < 0) begin
      if (start) begin
        m_age  = 1;
        m_pend = int'(A) * int'(B);
      end
    end else begin
      m_age++;
      if (m_age == 5) m_p = m_pend;
      if (m_age == 6) m_age = -1;
    end
  end

  always @(negedge clk) begin
    if (reset_n && chk_en) begin
      chk("P", P, m_p);
      chk("busy", busy, (m_age >= 1 && m_age <= 4));
      chk("done", done, (m_age == 5));
    end
  end

  int n_done = 0;
  int n_busy = 0;
  bit carry_seen = 1'b0;

  always @(posedge clk) begin
    if (done) n_done++;
    if (busy) n_busy++;
    if (busy && dut.w_carry) carry_seen = 1'b1;
  end

  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] lit, input string nm);
    int d0;
    int b0;
    int k;
    d0 = n_done;
    b0 = n_busy;
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " done-latency"}, k, 4);
    chk({nm, " P"}, P, lit);
    @(negedge clk);
    chk({nm, " done-count"}, n_done - d0, 1);
    chk({nm, " busy-cycles"}, n_busy - b0, 4);
    chk({nm, " P-hold"}, P, lit);
  endtask

  initial begin
    int d0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset P", P, 8'h00);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    run_op(4'd13, 4'd11, 8'h8F, "13x11");
    carry_seen = 1'b0;
    run_op(4'hF, 4'hF, 8'hE1, "15x15");
    chk("15x15 carry seen", carry_seen, 1'b1);
    run_op(4'd9, 4'd0, 8'h00, "9x0");
    run_op(4'd0, 4'd7, 8'h00, "0x7");

    // A second request while busy must be ignored.
    d0 = n_done;
    A = 4'd3;
    B = 4'd5;
    start = 1'b1;
    @(negedge clk);
    A = 4'd15;
    B = 4'd15;
    repeat (4) @(negedge clk);
    chk("ignore done", done, 1'b1);
    chk("ignore P", P, 8'd15);
    start = 1'b0;
    @(negedge clk);
    chk("ignore done-count", n_done - d0, 1);
    chk("ignore P-hold", P, 8'd15);
    @(negedge clk);
    chk("ignore no restart", busy, 1'b0);

    // An asynchronous reset in the 2nd CALC cycle aborts the operation.
    d0 = n_done;
    A = 4'd12;
    B = 4'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort P", P, 8'h00);
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort no done", n_done - d0, 0);
    run_op(4'd2, 4'd3, 8'd6, "2x3 after reset");

    // Exhaustive sweep with start held high, one operation every 6 cycles.
    d0 = n_done;
    start = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        A = 4'(a);
        B = 4'(b);
        repeat (6) @(negedge clk);
      end
    end
    start = 1'b0;
    chk("sweep done-count", n_done - d0, 256);
    chk("sweep last P", P, 8'hE1);
    @(negedge clk);
    chk("sweep idle", busy, 1'b0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
